// File: rtl/fault_test_pkg.sv
// fault_test_pkg
//   Shared types and constants for the fault test sequencer.
//   - seq_state_e : sequencer FSM states
//   - vec_entry_t : one table entry, {vec[2:0] = {x1,x2,x3}, exp = golden z}
//   - DEF_VEC / DEF_EXP : power-on contents of the vector table
//   - def_entry() : reset value of table entry i (000/0 beyond the defaults)
package fault_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [2:0] vec;
    logic       exp;
  } vec_entry_t;

  localparam int ENTRY_W = 4;
  localparam int DEF_NUM = 5;

  // Entry 0 sits in the most significant bits of both constants.
  localparam logic [14:0] DEF_VEC = {3'b010, 3'b110, 3'b111, 3'b101, 3'b110};
  localparam logic [4:0]  DEF_EXP = 5'b01101;

  function automatic vec_entry_t def_entry(input int i);
    vec_entry_t e;
    e = '0;
    case (i)
      0: e = '{vec: DEF_VEC[14:12], exp: DEF_EXP[4]};
      1: e = '{vec: DEF_VEC[11:9],  exp: DEF_EXP[3]};
      2: e = '{vec: DEF_VEC[8:6],   exp: DEF_EXP[2]};
      3: e = '{vec: DEF_VEC[5:3],   exp: DEF_EXP[1]};
      4: e = '{vec: DEF_VEC[2:0],   exp: DEF_EXP[0]};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/vec_table.sv
// vec_table
//   Register file of NUM_VEC test-vector entries with asynchronous reset to
//   the package defaults, one write port and one combinational read port.
//   Ports:
//     clk, rst_n      : clock, async active-low reset (restores defaults)
//     wr_en           : write strobe (caller gates it with busy)
//     wr_idx, wr_data : entry to write and its {vec,exp}; wr_idx >= NUM_VEC
//                       matches no entry, so the write is dropped
//     rd_idx, rd_data : combinational read
module vec_table
  import fault_test_pkg::*;
#(
  parameter int NUM_VEC = 5,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [ENTRY_W-1:0] rd_data
);

  vec_entry_t entries [NUM_VEC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        entries[i] <= def_entry(i);
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          entries[i] <= vec_entry_t'(wr_data);
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = entries[i];
      end
    end
  end

endmodule

// File: rtl/fault_test_sequencer.sv
// fault_test_sequencer
//   Applies a table of test vectors to a sequential circuit under test:
//   INIT_CYC homing clocks on vector 0, then each vector held HOLD_CYC clocks
//   with z compared against the golden bit at the end of every hold.
//   Ports:
//     clk, rst_n            : clock, async active-low reset
//     start                 : run request, honoured in IDLE only
//     load_en/idx/vec/exp   : table write, accepted while busy=0
//     x1, x2, x3            : registered CUT inputs (000 when not running)
//     z                     : CUT output
//     busy, done            : run in progress / one-cycle end-of-run pulse
//     pass, fail_cnt        : result of the last run
//     first_fail_idx/valid  : index of the first mismatching vector
//     state_dbg             : current FSM state (seq_state_e encoding)
//
//   Handshake: start and load_en are single-cycle strobes sampled on the
//   rising edge; start is consumed only in IDLE, load_en only while busy=0,
//   otherwise they are silently ignored. There is no back-pressure.
module fault_test_sequencer
  import fault_test_pkg::*;
#(
  parameter int NUM_VEC  = 5,
  parameter int HOLD_CYC = 2,
  parameter int INIT_CYC = 4,
  parameter int IDX_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [2:0]       load_vec,
  input  logic             load_exp,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   fail_cnt,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_valid,
  output logic [1:0]       state_dbg
);

  localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  seq_state_e       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [INIT_W-1:0] init_cnt, init_n;
  logic [IDX_W:0]   fail_q, fail_n;
  logic [IDX_W-1:0] ffi_q, ffi_n;
  logic             ffv_q, ffv_n;
  logic             pass_q, pass_n;
  logic             drive_n;
  logic             tbl_we;
  vec_entry_t       cur_q, cur_n, rd_entry, fetch;

  assign busy   = (state == INIT) || (state == APPLY);
  assign done   = (state == DONE);
  assign tbl_we = load_en && !busy;

  vec_table #(.NUM_VEC(NUM_VEC), .IDX_W(IDX_W)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tbl_we),
    .wr_idx  (load_idx),
    .wr_data ({load_vec, load_exp}),
    .rd_idx  (idx_n),
    .rd_data (rd_entry)
  );

  // cur_q holds the entry being applied. It is fetched one edge early
  // (indexed by idx_n) so x is a register output; a write landing on the
  // same edge as start is forwarded so the run uses the new entry.
  always_comb begin
    fetch = rd_entry;
    if (tbl_we && (load_idx == idx_n)) begin
      fetch = '{vec: load_vec, exp: load_exp};
    end
  end

  assign cur_n = drive_n ? fetch : '0;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    hold_n  = hold_cnt;
    init_n  = init_cnt;
    fail_n  = fail_q;
    ffi_n   = ffi_q;
    ffv_n   = ffv_q;
    pass_n  = pass_q;
    drive_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_n   = '0;
          hold_n  = '0;
          init_n  = '0;
          fail_n  = '0;
          ffv_n   = 1'b0;
          pass_n  = 1'b0;
          drive_n = 1'b1;
          state_n = (INIT_CYC > 0) ? INIT : APPLY;
        end
      end
      INIT: begin
        drive_n = 1'b1;
        if (init_cnt == INIT_W'(INIT_CYC - 1)) begin
          state_n = APPLY;
          idx_n   = '0;
          hold_n  = '0;
        end else begin
          init_n = init_cnt + INIT_W'(1);
        end
      end
      APPLY: begin
        drive_n = 1'b1;
        if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
          if (z != cur_q.exp) begin
            fail_n = fail_q + (IDX_W+1)'(1);
            if (!ffv_q) begin
              ffi_n = idx;
              ffv_n = 1'b1;
            end
          end
          if (idx == IDX_W'(NUM_VEC - 1)) begin
            state_n = DONE;
            drive_n = 1'b0;
          end else begin
            idx_n  = idx + IDX_W'(1);
            hold_n = '0;
          end
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      DONE: begin
        pass_n  = (fail_q == '0);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      hold_cnt <= '0;
      init_cnt <= '0;
      fail_q   <= '0;
      ffi_q    <= '0;
      ffv_q    <= 1'b0;
      pass_q   <= 1'b0;
      cur_q    <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      hold_cnt <= hold_n;
      init_cnt <= init_n;
      fail_q   <= fail_n;
      ffi_q    <= ffi_n;
      ffv_q    <= ffv_n;
      pass_q   <= pass_n;
      cur_q    <= cur_n;
    end
  end

  assign x1               = cur_q.vec[2];
  assign x2               = cur_q.vec[1];
  assign x3               = cur_q.vec[0];
  assign pass             = pass_q;
  assign fail_cnt         = fail_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;
  assign state_dbg        = state;

endmodule
